rsa_pre: RTL



---
 rtl/rsa_pre.sv | 77 +++++++
 1 files changed

// File: rtl/rsa_pre.sv
// Montgomery pre-processing: converts Y to T = Y*2^256 mod N by 256 modular
// doublings, one per cycle, with the multiplier's start/finish handshake.
module rsa_pre (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] N_i,
  input  logic [255:0] Y_i,
  output logic [255:0] T_o,
  output logic         finish,
  output logic         busy
);

  localparam int DATA_W = 256;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [8:0]        cnt;
  logic [DATA_W-1:0] n_r;
  logic [DATA_W-1:0] t_r;
  logic [DATA_W-1:0] t_nxt;

  // The double keeps its carry bit so the compare against N is exact even
  // when T has its top bit set; the reduced result always fits back in 256 bits.
  function automatic logic [DATA_W-1:0] mod_dbl(input logic [DATA_W-1:0] t,
                                                input logic [DATA_W-1:0] n);
    logic [DATA_W:0] d;
    d = {t, 1'b0};
    if (d >= {1'b0, n})
      d = d - {1'b0, n};
    return d[DATA_W-1:0];
  endfunction

  assign t_nxt = mod_dbl(t_r, n_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
      T_o    <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 9'd1;
          if (cnt == 9'd255) begin
            state  <= IDLE;
            busy   <= 1'b0;
            finish <= 1'b1;
            T_o    <= t_nxt;
          end
        end
      endcase
    end
  end

  // Operand registers: loaded on accept, iterated in RUN, left unreset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      n_r <= N_i;
      t_r <= Y_i;
    end else if (state == RUN) begin
      t_r <= t_nxt;
    end
  end

endmodule
